// File: rtl/alarm_melody_player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : melody_pkg
// Brief    : Shared types, note table and half-period helper for the player.
// Revision : 1.0 - initial release
// ============================================================================
package melody_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    localparam logic [3:0] NOTE_REST = 4'd0;

    localparam int c_HALF_W = 24;
    typedef logic [c_HALF_W-1:0] half_t;

    // Zero marks a rest; codes 10..15 are rests as well.
    localparam int c_NOTE_HZ [16] = '{
        0, 523, 587, 659, 698, 784, 880, 988, 1047, 1175,
        0, 0, 0, 0, 0, 0
    };

    function automatic logic is_tone(input logic [3:0] code);
        return (code != NOTE_REST) && (c_NOTE_HZ[code] != 0);
    endfunction

    function automatic half_t half_period(input logic [3:0] code, input int clk_hz);
        int f;
        int h;
        f = c_NOTE_HZ[code];
        if (f == 0) begin
            h = 1;
        end else begin
            h = clk_hz / (2 * f);
        end
        if (h < 1) begin
            h = 1;
        end
        return half_t'(h);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_melody_player_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_melody_player_if
// Brief    : Control, buzzer and melody-ROM signals of the alarm melody player.
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_melody_player_if;

    logic       start;
    logic       stop;
    logic       repeat_en;
    logic [3:0] rom_dout;
    logic [7:0] rom_ad;
    logic       rom_ce;
    logic       rom_oce;
    logic       buzzer;
    logic       busy;
    logic       done;

    modport master (
        input  start, stop, repeat_en, rom_dout,
        output rom_ad, rom_ce, rom_oce, buzzer, busy, done
    );

    modport slave (
        output start, stop, repeat_en, rom_dout,
        input  rom_ad, rom_ce, rom_oce, buzzer, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/alarm_melody_player_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : tone_gen
// Brief    : Square-wave generator toggling every half-period while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module tone_gen
    import melody_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire half_t i_half,
    input  wire logic  i_load,
    input  wire logic  i_en,
    output logic       o_buzzer
);

    half_t r_half;
    half_t r_cnt;
    logic  r_buzzer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_half   <= half_t'(1);
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end else if (i_load) begin
            r_half   <= i_half;
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == r_half - half_t'(1)) begin
                r_cnt    <= '0;
                r_buzzer <= ~r_buzzer;
            end else begin
                r_cnt    <= r_cnt + half_t'(1);
            end
        end else begin
            // Gap, rest or abort: hold the line low.
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end
    end

    assign o_buzzer = r_buzzer;

endmodule
`default_nettype wire

// File: rtl/alarm_melody_player.sv
`default_nettype none
// ============================================================================
// Module   : alarm_melody_player
// Brief    : Steps through melody-ROM note codes and drives a buzzer tone.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_melody_player
    import melody_pkg::*;
#(
    parameter int         CLK_HZ      = 27_000_000,
    parameter int         NOTE_CYCLES = 6_750_000,
    parameter int         GAP_CYCLES  = 675_000,
    parameter int         MELODY_LEN  = 64,
    parameter logic [7:0] BASE_ADDR   = 8'd0
)
(
    input  wire logic             clk,
    input  wire logic             reset,
    alarm_melody_player_if.master bus
);

    localparam int                  c_SLOT_W    = $clog2(NOTE_CYCLES);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(NOTE_CYCLES - 3);
    // Tone runs while the slot counter is below this; the registered buzzer
    // then reads low for exactly GAP_CYCLES clocks at the end of PLAY.
    localparam logic [c_SLOT_W-1:0] c_TONE_END  = c_SLOT_W'(NOTE_CYCLES - 3 - GAP_CYCLES);
    localparam logic [7:0]          c_IDX_LAST  = 8'(MELODY_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_idx;
    logic [7:0]          w_idx_nxt;
    logic [c_SLOT_W-1:0] r_slot;
    logic [c_SLOT_W-1:0] w_slot_nxt;
    logic [3:0]          r_note;
    logic [3:0]          w_note_nxt;
    logic                w_done_nxt;
    logic                w_tone_load;
    logic                w_tone_en;

    logic [7:0]          r_rom_ad;
    logic                r_rom_ce;
    logic                r_busy;
    logic                r_done;

    half_t               w_half_tbl [16];
    half_t               w_half;

    for (genvar g = 0; g < 16; g++) begin : g_half_tbl
        assign w_half_tbl[g] = half_period(4'(g), CLK_HZ);
    end

    assign w_half = w_half_tbl[bus.rom_dout];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_slot_nxt  = r_slot;
        w_note_nxt  = r_note;
        w_done_nxt  = 1'b0;
        w_tone_load = 1'b0;
        w_tone_en   = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                if (bus.start && !bus.stop) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_note_nxt  = bus.rom_dout;
                w_slot_nxt  = '0;
                w_tone_load = 1'b1;
                w_state_nxt = PLAY;
            end
            PLAY: begin
                w_slot_nxt = r_slot + c_SLOT_W'(1);
                w_tone_en  = is_tone(r_note) && (r_slot < c_TONE_END);
                if (r_slot == c_SLOT_LAST) begin
                    w_slot_nxt = '0;
                    if (r_idx != c_IDX_LAST) begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_state_nxt = FETCH;
                    end else if (bus.repeat_en) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = FETCH;
                    end else begin
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if ((r_state != IDLE) && bus.stop) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_slot_nxt  = '0;
            w_done_nxt  = 1'b0;
            w_tone_load = 1'b0;
            w_tone_en   = 1'b0;
        end
    end

    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_slot   <= '0;
            r_note   <= NOTE_REST;
            r_rom_ad <= BASE_ADDR;
            r_rom_ce <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_slot   <= w_slot_nxt;
            r_note   <= w_note_nxt;
            r_rom_ad <= BASE_ADDR + w_idx_nxt;
            r_rom_ce <= (w_state_nxt == FETCH);
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
        end
    end

    tone_gen u_tone_gen (
        .clk      (clk),
        .reset    (reset),
        .i_half   (w_half),
        .i_load   (w_tone_load),
        .i_en     (w_tone_en),
        .o_buzzer (bus.buzzer)
    );

    assign bus.rom_ad  = r_rom_ad;
    assign bus.rom_ce  = r_rom_ce;
    assign bus.rom_oce = 1'b1;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alarm_melody_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_melody_player
// Brief    : Directed self-checking bench for the alarm melody player.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_melody_player;

    localparam int c_NOTE = 40;
    localparam int c_PASS = 4 * c_NOTE;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alarm_melody_player_if bus_a ();
    alarm_melody_player_if bus_b ();

    alarm_melody_player #(
        .CLK_HZ(10460), .NOTE_CYCLES(40), .GAP_CYCLES(4), .MELODY_LEN(4), .BASE_ADDR(8'd0)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    alarm_melody_player #(
        .CLK_HZ(10460), .NOTE_CYCLES(40), .GAP_CYCLES(4), .MELODY_LEN(4), .BASE_ADDR(8'd254)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    logic [3:0] mem [256];

    always @(posedge clk) begin
        if (bus_a.rom_ce) bus_a.rom_dout <= mem[bus_a.rom_ad];
        if (bus_b.rom_ce) bus_b.rom_dout <= mem[bus_b.rom_ad];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Half-periods at 10460 Hz, worked out by hand; 0 means silent code.
    function automatic int exp_half(input logic [3:0] code);
        case (code)
            4'd1: return 10;
            4'd2: return 8;
            4'd3: return 7;
            4'd4: return 7;
            4'd5: return 6;
            4'd6: return 5;
            4'd7: return 5;
            4'd8: return 4;
            4'd9: return 4;
            default: return 0;
        endcase
    endfunction

    // p = cycles since PLAY entry; tone audible for p in [0, 34).
    function automatic logic exp_buz(input logic [3:0] code, input int p);
        int h;
        h = exp_half(code);
        if (h == 0 || p < 0 || p >= 34) return 1'b0;
        return ((p / h) % 2) == 1;
    endfunction

    // Called in the FETCH cycle of note 0; returns in the cycle after the pass.
    task automatic run_pass(input string tag, input int pulse_at);
        int e_ce, e_ad, e_buz, e_busy, e_done;
        int s, k;
        e_ce = 0; e_ad = 0; e_buz = 0; e_busy = 0; e_done = 0;
        for (int t = 0; t < c_PASS; t++) begin
            s = t % c_NOTE;
            k = t / c_NOTE;
            if (bus_a.rom_ce !== (s == 0)) e_ce++;
            if (s == 0 && bus_a.rom_ad !== 8'(k)) e_ad++;
            if (bus_a.buzzer !== exp_buz(mem[k], s - 2)) e_buz++;
            if (bus_a.busy !== 1'b1) e_busy++;
            if (bus_a.done !== 1'b0) e_done++;
            bus_a.start = (t == pulse_at);
            @(negedge clk);
        end
        check({tag, " rom_ce timing errs"}, e_ce, 0);
        check({tag, " rom_ad errs"}, e_ad, 0);
        check({tag, " buzzer errs"}, e_buz, 0);
        check({tag, " busy errs"}, e_busy, 0);
        check({tag, " early done errs"}, e_done, 0);
    endtask

    task automatic check_done(input string tag);
        check({tag, " done pulse"}, bus_a.done, 1);
        check({tag, " busy low"}, bus_a.busy, 0);
        @(negedge clk);
        check({tag, " done cleared"}, bus_a.done, 0);
    endtask

    task automatic pulse_start;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    int cnt;
    int addrs [8];
    int n_done_b;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'd0;
        mem[0] = 4'd1; mem[1] = 4'd8; mem[2] = 4'd0; mem[3] = 4'd12;
        mem[254] = 4'd1; mem[255] = 4'd2;

        reset = 1'b1;
        bus_a.start = 0; bus_a.stop = 0; bus_a.repeat_en = 0;
        bus_b.start = 0; bus_b.stop = 0; bus_b.repeat_en = 0;
        repeat (3) @(negedge clk);
        check("reset rom_ad", bus_a.rom_ad, 0);
        check("reset rom_ce", bus_a.rom_ce, 0);
        check("reset buzzer", bus_a.buzzer, 0);
        check("reset busy", bus_a.busy, 0);
        check("reset done", bus_a.done, 0);
        check("rom_oce const", bus_a.rom_oce, 1);
        check("reset rom_ad base254", bus_b.rom_ad, 254);
        reset = 1'b0;
        @(negedge clk);

        // Single pass
        pulse_start();
        run_pass("p1", -1);
        check_done("p1");
        repeat (5) @(negedge clk);

        // Repeat pass, then drop repeat_en during the second pass
        bus_a.repeat_en = 1'b1;
        pulse_start();
        run_pass("rep1", -1);
        bus_a.repeat_en = 1'b0;
        run_pass("rep2", -1);
        check_done("rep2");
        repeat (5) @(negedge clk);

        // Stop mid-note while the buzzer is high
        pulse_start();
        repeat (12) @(negedge clk);
        check("stop pre buzzer high", bus_a.buzzer, 1);
        bus_a.stop = 1'b1;
        @(negedge clk);
        bus_a.stop = 1'b0;
        check("stop buzzer", bus_a.buzzer, 0);
        check("stop busy", bus_a.busy, 0);
        check("stop done", bus_a.done, 0);
        check("stop rom_ce", bus_a.rom_ce, 0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus_a.busy || bus_a.rom_ce || bus_a.done) cnt++;
            @(negedge clk);
        end
        check("stop stays idle", cnt, 0);

        // Reset during PLAY, then replay from the first note
        pulse_start();
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset rom_ad", bus_a.rom_ad, 0);
        check("midreset rom_ce", bus_a.rom_ce, 0);
        check("midreset buzzer", bus_a.buzzer, 0);
        check("midreset busy", bus_a.busy, 0);
        check("midreset done", bus_a.done, 0);
        @(negedge clk);
        pulse_start();
        run_pass("post-reset", -1);
        check_done("post-reset");

        // start+stop in IDLE stays idle; start while busy is ignored
        bus_a.start = 1'b1; bus_a.stop = 1'b1;
        repeat (2) @(negedge clk);
        check("start+stop busy", bus_a.busy, 0);
        check("start+stop rom_ce", bus_a.rom_ce, 0);
        bus_a.start = 1'b0; bus_a.stop = 1'b0;
        @(negedge clk);
        pulse_start();
        run_pass("busy-start", 50);
        check_done("busy-start");

        // 8-bit address wrap from BASE_ADDR=254
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        cnt = 0;
        n_done_b = 0;
        for (int i = 0; i < c_PASS + 10; i++) begin
            if (bus_b.rom_ce) begin
                if (cnt < 8) addrs[cnt] = int'(bus_b.rom_ad);
                cnt++;
            end
            if (bus_b.done) n_done_b++;
            @(negedge clk);
        end
        check("wrap fetch count", cnt, 4);
        check("wrap ad0", addrs[0], 254);
        check("wrap ad1", addrs[1], 255);
        check("wrap ad2", addrs[2], 0);
        check("wrap ad3", addrs[3], 1);
        check("wrap done count", n_done_b, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
